// File: rtl/ifetch_pkg.sv
// Shared types for the Saratoga fetch stage: the RV32 word type and the
// ifetch FSM state / instruction buffer entry definitions.
package rv32;
   typedef logic [31:0] word;
endpackage

package saratoga;
   typedef enum logic [1:0] {
      IF_REQ,
      IF_WAIT,
      IF_DROP
   } ifetch_state_t;

   localparam int IFETCH_BUF_DEPTH = 2;

   typedef struct packed {
      rv32::word inst;
      rv32::word pc;
      logic      fault;
   } ifetch_entry_t;
endpackage

// File: rtl/ifetch_buf.sv
// Circular FIFO of fetched instructions; the head entry is read straight out
// of the storage registers, so consumers never see a bus-to-output path.
module ifetch_buf
   import saratoga::*;
#(
   parameter int DEPTH = IFETCH_BUF_DEPTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  ifetch_entry_t push_data,
   input  logic          pop,
   input  logic          flush,
   output ifetch_entry_t head,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);

   ifetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: storage is reset as well so the head reads all-zero out of reset;
   // the array is only DEPTH entries, so the reset fan-out is cheap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: issues pc on the instruction bus, tracks one outstanding
// read and queues responses for Decode. Optional: IFETCH_MISALIGN_TRAP_EN.
module ifetch
   import saratoga::*;
#(
   parameter int BUF_DEPTH = IFETCH_BUF_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  rv32::word pc,
   input  logic      next_pc_en,
   output logic      stall_fetch,
   output logic      ibus_req,
   output rv32::word ibus_addr,
   input  logic      ibus_gnt,
   input  logic      ibus_rvalid,
   input  rv32::word ibus_rdata,
   input  logic      ibus_err,
   output logic      inst_valid,
   output rv32::word inst,
   output rv32::word inst_pc,
   output logic      inst_fault,
   input  logic      decode_ready
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   ifetch_state_t state;
   rv32::word     pend_pc;
   ifetch_entry_t head;
   ifetch_entry_t push_data;
   logic [CW-1:0] count;
   logic [CW:0]   occ_after;
   logic          full;
   logic          empty;
   logic          flush;
   logic          pop;
   logic          push;
   logic          accept;
   logic          issue_a;
   logic          issue_b;
   logic          rsp_keep;
   logic          misaligned;
   logic          mis_push;

   assign flush      = next_pc_en;
   assign inst_valid = !empty;
   assign pop        = inst_valid && decode_ready;
   assign ibus_addr  = pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misaligned = (state == IF_REQ) && (pc[1:0] != 2'b00);
   assign mis_push   = misaligned && !flush && !full;
`else
   assign misaligned = 1'b0;
   assign mis_push   = 1'b0;
`endif

   // Occupancy once the arriving response is pushed and any pop retires;
   // issuing only below depth reserves the slot for the next response.
   assign occ_after = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

   assign issue_a     = (state == IF_REQ) && !full && !misaligned;
   assign issue_b     = (state == IF_WAIT) && ibus_rvalid && (occ_after < (CW+1)'(BUF_DEPTH));
   assign ibus_req    = !flush && (issue_a || issue_b);
   assign accept      = ibus_req && ibus_gnt;
   assign stall_fetch = !(accept || flush || mis_push);
   assign rsp_keep    = (state == IF_WAIT) && ibus_rvalid && !flush;
   assign push        = rsp_keep || mis_push;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      push_data.inst  = ibus_rdata;
      push_data.pc    = pend_pc;
      push_data.fault = ibus_err;
      if (mis_push) begin
         push_data.inst  = '0;
         push_data.pc    = pc;
         push_data.fault = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IF_REQ;
         pend_pc <= '0;
      end else begin
         if (accept) pend_pc <= pc;
         case (state)
            IF_REQ: begin
               if (accept) state <= IF_WAIT;
            end
            IF_WAIT: begin
               if (ibus_rvalid) state <= accept ? IF_WAIT : IF_REQ;
               else if (flush)  state <= IF_DROP;
            end
            IF_DROP: begin
               if (ibus_rvalid) state <= IF_REQ;
            end
            default: state <= IF_REQ;
         endcase
      end
   end

   ifetch_buf #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .flush    (flush),
      .head     (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   assign inst       = head.inst;
   assign inst_pc    = head.pc;
   assign inst_fault = head.fault;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch (default build, BUF_DEPTH = 2).
module tb_ifetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc;
   logic        next_pc_en;
   logic        stall_fetch;
   logic        ibus_req;
   logic [31:0] ibus_addr;
   logic        ibus_gnt;
   logic        ibus_rvalid;
   logic [31:0] ibus_rdata;
   logic        ibus_err;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_fault;
   logic        decode_ready;

   logic [31:0] next_pc;
   logic        auto_bus;
   int          checks;
   int          failures;

   ifetch #(.BUF_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .next_pc_en  (next_pc_en),
      .stall_fetch (stall_fetch),
      .ibus_req    (ibus_req),
      .ibus_addr   (ibus_addr),
      .ibus_gnt    (ibus_gnt),
      .ibus_rvalid (ibus_rvalid),
      .ibus_rdata  (ibus_rdata),
      .ibus_err    (ibus_err),
      .inst_valid  (inst_valid),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_fault  (inst_fault),
      .decode_ready(decode_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Called at the negedge: captures pre-edge controls, crosses the posedge,
   // then updates the PC register model and, in auto mode, the zero-wait bus.
   task automatic tick();
      logic        st;
      logic        fl;
      logic        acc;
      logic [31:0] np;
      logic [31:0] acc_addr;
      st       = stall_fetch;
      fl       = next_pc_en;
      np       = next_pc;
      acc      = ibus_req && ibus_gnt;
      acc_addr = ibus_addr;
      @(posedge clk);
      #1;
      if (fl)       pc = np;
      else if (!st) pc = pc + 32'd4;
      if (auto_bus) begin
         ibus_gnt    = 1'b1;
         ibus_rvalid = acc;
         ibus_rdata  = mem_word(acc_addr);
         ibus_err    = 1'b0;
      end
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      pc           = 32'h0;
      next_pc      = 32'h0;
      next_pc_en   = 1'b0;
      ibus_gnt     = 1'b0;
      ibus_rvalid  = 1'b0;
      ibus_rdata   = 32'h0;
      ibus_err     = 1'b0;
      decode_ready = 1'b1;
      auto_bus     = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_inst_fault", inst_fault, 0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      auto_bus = 1'b1;
      ibus_gnt = 1'b1;

      // Zero-wait streaming from PC 0: one instruction per cycle from cycle 2
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t1_req", ibus_req, 1);
         check("t1_addr", ibus_addr, 32'(4 * k));
         check("t1_stall", stall_fetch, 0);
         if (k >= 2) begin
            check("t1_valid", inst_valid, 1);
            check("t1_inst_pc", inst_pc, 32'(4 * (k - 2)));
            check("t1_inst", inst, mem_word(32'(4 * (k - 2))));
         end else begin
            check("t1_valid_early", inst_valid, 0);
         end
         tick();
      end

      // Decode stalls 6 cycles: buffer fills to 2, no requests, PC held at 0x18
      decode_ready = 1'b0;
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("t2_req", ibus_req, 0);
         check("t2_stall", stall_fetch, 1);
         check("t2_addr", ibus_addr, 32'h18);
         check("t2_head_pc", inst_pc, 32'h10);
         tick();
      end
      decode_ready = 1'b1;
      @(negedge clk);
      check("t2_rel0_pc", inst_pc, 32'h10);
      check("t2_rel0_req", ibus_req, 0);
      check("t2_rel0_stall", stall_fetch, 1);
      tick();
      @(negedge clk);
      check("t2_rel1_pc", inst_pc, 32'h14);
      check("t2_rel1_inst", inst, mem_word(32'h14));
      check("t2_rel1_req", ibus_req, 1);
      check("t2_rel1_addr", ibus_addr, 32'h18);
      tick();
      @(negedge clk);
      check("t2_rel2_valid", inst_valid, 0);
      tick();
      @(negedge clk);
      check("t2_rel3_pc", inst_pc, 32'h18);
      check("t2_rel3_inst", inst, mem_word(32'h18));
      tick();

      // Redirect to 0x100 with a response arriving the same cycle
      next_pc_en = 1'b1;
      next_pc    = 32'h100;
      @(negedge clk);
      check("t3_flush_req", ibus_req, 0);
      check("t3_flush_stall", stall_fetch, 0);
      tick();
      auto_bus    = 1'b0;
      next_pc_en  = 1'b0;
      ibus_gnt    = 1'b0;
      ibus_rvalid = 1'b0;

      // Grant delayed 3 cycles: PC holds at 0x100
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check("t3_wait_req", ibus_req, 1);
         check("t3_wait_addr", ibus_addr, 32'h100);
         check("t3_wait_stall", stall_fetch, 1);
         check("t3_no_stale", inst_valid, 0);
         tick();
      end
      ibus_gnt = 1'b1;
      @(negedge clk);
      check("t3_gnt_addr", ibus_addr, 32'h100);
      check("t3_gnt_stall", stall_fetch, 0);
      tick();
      ibus_gnt = 1'b0;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         check("t3_rsp_wait_req", ibus_req, 0);
         check("t3_rsp_wait_stall", stall_fetch, 1);
         tick();
      end
      ibus_rvalid = 1'b1;
      ibus_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t3_rsp_req", ibus_req, 1);
      check("t3_rsp_stall", stall_fetch, 1);
      check("t3_rsp_valid", inst_valid, 0);
      tick();
      ibus_rvalid = 1'b0;
      ibus_gnt    = 1'b1;
      @(negedge clk);
      check("t3_inst_valid", inst_valid, 1);
      check("t3_inst", inst, 32'hDEAD_BEEF);
      check("t3_inst_pc", inst_pc, 32'h100);
      check("t3_next_addr", ibus_addr, 32'h104);
      tick();

      // Redirect to 0x200 while 0x10C is outstanding; its data is dropped
      ibus_rvalid = 1'b1;
      ibus_rdata  = 32'h1111_0104;
      @(negedge clk);
      tick();
      ibus_rdata = 32'h1111_0108;
      @(negedge clk);
      check("t4_issue_addr", ibus_addr, 32'h10C);
      check("t4_issue_req", ibus_req, 1);
      tick();
      ibus_rvalid = 1'b0;
      ibus_gnt    = 1'b0;
      next_pc_en  = 1'b1;
      next_pc     = 32'h200;
      @(negedge clk);
      check("t4_flush_req", ibus_req, 0);
      check("t4_flush_stall", stall_fetch, 0);
      tick();
      next_pc_en = 1'b0;
      @(negedge clk);
      check("t4_empty", inst_valid, 0);
      check("t4_drop_req", ibus_req, 0);
      check("t4_drop_stall", stall_fetch, 1);
      tick();
      ibus_rvalid = 1'b1;
      ibus_rdata  = 32'h0BAD_010C;
      @(negedge clk);
      check("t4_dropping_req", ibus_req, 0);
      check("t4_dropping_valid", inst_valid, 0);
      tick();
      ibus_rvalid = 1'b0;
      ibus_gnt    = 1'b1;
      @(negedge clk);
      check("t4_after_drop_valid", inst_valid, 0);
      check("t4_new_req", ibus_req, 1);
      check("t4_new_addr", ibus_addr, 32'h200);
      check("t4_new_stall", stall_fetch, 0);
      tick();
      ibus_rvalid = 1'b1;
      ibus_rdata  = 32'h2222_0200;
      ibus_gnt    = 1'b0;
      @(negedge clk);
      tick();

      // Redirect to 0x40; bus error on its read
      ibus_rvalid = 1'b0;
      next_pc_en  = 1'b1;
      next_pc     = 32'h40;
      @(negedge clk);
      check("t4_new_valid", inst_valid, 1);
      check("t4_new_inst_pc", inst_pc, 32'h200);
      check("t4_new_inst", inst, 32'h2222_0200);
      tick();
      next_pc_en = 1'b0;
      ibus_gnt   = 1'b1;
      @(negedge clk);
      check("t5_addr", ibus_addr, 32'h40);
      check("t5_req", ibus_req, 1);
      check("t5_flushed", inst_valid, 0);
      tick();
      ibus_rvalid = 1'b1;
      ibus_err    = 1'b1;
      ibus_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("t5_addr2", ibus_addr, 32'h44);
      check("t5_req2", ibus_req, 1);
      tick();
      ibus_err   = 1'b0;
      ibus_rdata = 32'h3333_0044;
      ibus_gnt   = 1'b0;
      @(negedge clk);
      check("t5_fault_valid", inst_valid, 1);
      check("t5_fault", inst_fault, 1);
      check("t5_fault_pc", inst_pc, 32'h40);
      tick();
      ibus_rvalid  = 1'b0;
      ibus_gnt     = 1'b1;
      decode_ready = 1'b0;
      @(negedge clk);
      check("t5_ok_fault", inst_fault, 0);
      check("t5_ok_pc", inst_pc, 32'h44);
      check("t5_ok_inst", inst, 32'h3333_0044);
      check("t5_ok_addr", ibus_addr, 32'h48);
      tick();

      // Asynchronous reset while a read is outstanding
      ibus_gnt = 1'b0;
      @(negedge clk);
      check("t6_pre_valid", inst_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", inst_valid, 0);
      check("t6_rst_inst", inst, 0);
      check("t6_rst_inst_pc", inst_pc, 0);
      pc           = 32'h80;
      decode_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n    = 1'b1;
      ibus_gnt = 1'b1;
      @(negedge clk);
      check("t6_restart_req", ibus_req, 1);
      check("t6_restart_addr", ibus_addr, 32'h80);
      check("t6_restart_stall", stall_fetch, 0);
      check("t6_restart_valid", inst_valid, 0);
      tick();
      ibus_rvalid = 1'b1;
      ibus_rdata  = 32'h4444_0080;
      ibus_gnt    = 1'b0;
      @(negedge clk);
      tick();
      ibus_rvalid = 1'b0;
      @(negedge clk);
      check("t6_inst_valid", inst_valid, 1);
      check("t6_inst_pc", inst_pc, 32'h80);
      check("t6_inst", inst, 32'h4444_0080);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the Saratoga core's Fetch Stage, the consumer side of the program counter. It drives the current `pc` onto the instruction bus and tracks one outstanding read. It produces `stall_fetch`, so the PC advances only when a request is accepted or a redirect occurs. Returned instructions are queued with their address in a small buffer that feeds Decode through a valid/ready handshake.

## Interface
Parameters:
- BUF_DEPTH, 2, instruction buffer entries; power of two, ≥2

Ports:
- clk  in  1  system clock
- rst_n  in  1  global reset, asynchronous, active-low
- pc  in  rv32::word  current PC from the PC register
- next_pc_en  in  1  redirect/flush; same signal that loads `next_pc` into the PC
- stall_fetch  out  1  hold PC
- ibus_req  out  1  read request valid
- ibus_addr  out  rv32::word  read address
- ibus_gnt  in  1  request accepted this cycle
- ibus_rvalid  in  1  read data valid; exactly one per granted request, no earlier than the cycle after grant
- ibus_rdata  in  rv32::word  read data
- ibus_err  in  1  bus error, qualified by `ibus_rvalid`
- inst_valid  out  1  buffer head valid
- inst  out  rv32::word  instruction at head
- inst_pc  out  rv32::word  address of `inst`
- inst_fault  out  1  head entry faulted
- decode_ready  in  1  Decode consumes head when high with `inst_valid`

## Operation
- FSM in saratoga::ifetch_state_t.
  - IF_REQ: no request outstanding.
  - IF_WAIT: one request outstanding, its response kept.
  - IF_DROP: one request outstanding, its response discarded.
- Definitions:
  - `count` = buffer occupancy.
  - pop = `inst_valid && decode_ready`.
  - flush = `next_pc_en`.
  - accept = `ibus_req && ibus_gnt`.
- `ibus_addr` = `pc` combinationally.
- `ibus_req` = !flush && (A || B):
  - A: IF_REQ && count < BUF_DEPTH.
  - B: IF_WAIT && ibus_rvalid && count + 1 − pop < BUF_DEPTH.
  - Case B gives back-to-back issue.
- `stall_fetch` = !(accept || flush).
- On accept, latch `pc` into `pend_pc`.
- Transitions:
  - IF_REQ: accept → IF_WAIT.
  - IF_WAIT, rvalid without flush:
    - Push {rdata, pend_pc, err} into the buffer.
    - Next state is IF_WAIT if accept occurs this cycle, else IF_REQ.
  - IF_WAIT, flush and rvalid in the same cycle: discard the response → IF_REQ.
  - IF_WAIT, flush without rvalid → IF_DROP.
  - IF_DROP, rvalid: discard the response → IF_REQ. A flush while in IF_DROP stays in IF_DROP.
- Flush empties the buffer, taking effect the next cycle. A pop coincident with a flush is legal and ignored.
- Push and pop in the same cycle when full is impossible by construction, because issue reserves a slot.
- Buffer is a circular FIFO. Read and write pointers are $clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. `count` is $clog2(BUF_DEPTH)+1 bits.

## Timing
- Async reset sets:
  - state=IF_REQ, count=0, pointers=0, pend_pc=0.
  - Outputs: `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_fault`=0.
- `ibus_req` and `stall_fetch` are combinational. In the first cycle after reset release, `ibus_req`=1 and `stall_fetch`=!ibus_gnt.
- Reset mid-transaction abandons the outstanding read. The bus is reset by the same `rst_n`.
- Zero-wait bus:
  - gnt at cycle N, rvalid at N+1, `inst_valid` at N+2.
  - Sustained rate is 1 instruction per cycle while Decode is ready.
- Redirect at cycle N:
  - PC loads `next_pc` at the N+1 edge.
  - First request to the new address at N+1 if in IF_REQ; otherwise after the dropped response.
  - No stale instruction is visible from N+1 on.
- `inst*` are registered from buffer storage. There is no rdata→inst combinational path.

## Configuration
- IFETCH_MISALIGN_TRAP_EN
  - Defined: when `pc[1:0]` ≠ 0 in IF_REQ, no bus request is made. Instead:
    - A faulted entry {inst=0, inst_pc=pc, fault=1} is pushed directly.
    - `stall_fetch` is released for that cycle.
    - State remains IF_REQ.
  - Undefined: `pc[1:0]` is ignored and the address is issued as is.

## Structure
- Add to package saratoga:
  - ifetch_state_t enum.
  - IFETCH_BUF_DEPTH default constant.
  - ifetch_entry_t packed struct {word inst; word pc; logic fault}.
- One sub-module, ifetch_buf: a parameterised FIFO of ifetch_entry_t with push/pop/flush, count, full/empty. It uses the same async active-low reset.

## Test plan
- Reset, zero-wait bus, PC 0x0000_0000 → addresses 0x0, 0x4, 0x8; `inst_valid` from cycle 2; one instruction per cycle; matching `inst_pc`.
- `decode_ready`=0 for 6 cycles → exactly BUF_DEPTH entries buffered; `ibus_req`=0 and `stall_fetch`=1 while full; order preserved on release.
- gnt delayed 3 cycles and rvalid delayed 2 more → PC holds at 0x100 throughout; `inst`=rdata with `inst_pc`=0x100.
- `next_pc_en` to 0x200 while a read of 0x10C is outstanding, rvalid 2 cycles later → 0x10C data dropped, buffer empty; next address 0x200 is issued after the drop.
- `ibus_err` with rvalid for 0x40 → entry `inst_fault`=1, `inst_pc`=0x40; following fetches unaffected.
- `rst_n` asserted mid-IF_WAIT, asynchronously, not on a clock edge → `inst_valid`=0 immediately; fetch restarts cleanly after release.
